// File: rtl/pe_frc_accumulator.sv
// Force accumulator back-end for one processing element.
// Home stream: sums the home-particle force over consecutive pairs that share
// a home ID and emits one total per home particle.
// Neighbour stream: accumulates the negated force into one-hot-selected slots
// and, on release, pushes the slot result into a show-ahead output FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_frc_valid / i_frc           pair force valid, {fz,fy,fx} home force
//   i_home_parid                  home particle ID of the pair
//   i_nb_parid / i_nb_cid         neighbour particle ID / cell ID {z,y,x}
//   i_slot_sel / i_release        one-hot slot select, release slot after pair
//   i_home_flush                  emit current home total
//   o_home_frc/_parid/_valid      home total, its ID, one-cycle pulse
//   o_nb_frc/_parid/_cid/_valid   FIFO head (show-ahead), valid
//   i_nb_ready                    downstream pops head
//   o_back_pressure               FIFO count >= FIFO_DEPTH-2
//   o_idle                        no active slot / home total, FIFO empty
//   o_err                         sticky {FIFO overflow, bad slot select}
module pe_frc_accumulator #(
  parameter int unsigned FRC_WIDTH   = 32,
  parameter int unsigned PARID_WIDTH = 9,
  parameter int unsigned CID_WIDTH   = 3,
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_frc_valid,
  input  logic [3*FRC_WIDTH-1:0]     i_frc,
  input  logic [PARID_WIDTH-1:0]     i_home_parid,
  input  logic [PARID_WIDTH-1:0]     i_nb_parid,
  input  logic [3*CID_WIDTH-1:0]     i_nb_cid,
  input  logic [NUM_SLOTS-1:0]       i_slot_sel,
  input  logic                       i_release,
  input  logic                       i_home_flush,
  output logic [3*FRC_WIDTH-1:0]     o_home_frc,
  output logic [PARID_WIDTH-1:0]     o_home_parid,
  output logic                       o_home_valid,
  output logic [3*FRC_WIDTH-1:0]     o_nb_frc,
  output logic [PARID_WIDTH-1:0]     o_nb_parid,
  output logic [3*CID_WIDTH-1:0]     o_nb_cid,
  output logic                       o_nb_valid,
  input  logic                       i_nb_ready,
  output logic                       o_back_pressure,
  output logic                       o_idle,
  output logic [1:0]                 o_err
);

  localparam int unsigned FW   = FRC_WIDTH;
  localparam int unsigned PW   = PARID_WIDTH;
  localparam int unsigned CW   = 3 * CID_WIDTH;
  localparam int unsigned NS   = NUM_SLOTS;
  localparam int unsigned FD   = FIFO_DEPTH;
  localparam int unsigned AW   = $clog2(FD);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned EW   = 3 * FW + PW + CW;

  // Symmetric saturation bounds, held one bit wider than a component.
  localparam logic signed [FW:0] SMAX = {2'b00, {(FW-1){1'b1}}};
  localparam logic signed [FW:0] SMIN = -SMAX;

  typedef logic [2:0][FW-1:0] frc_t;

  function automatic logic [FW-1:0] sat_clip(input logic signed [FW:0] s);
    logic [FW-1:0] r;
    if (s > SMAX)      r = SMAX[FW-1:0];
    else if (s < SMIN) r = SMIN[FW-1:0];
    else               r = s[FW-1:0];
    return r;
  endfunction

  function automatic logic [FW-1:0] sat_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic signed [FW:0] s;
    s = $signed({a[FW-1], a}) + $signed({b[FW-1], b});
    return sat_clip(s);
  endfunction

  // Negating the minimum value lands on +max.
  function automatic logic [FW-1:0] sat_neg(input logic [FW-1:0] a);
    logic signed [FW:0] s;
    s = -$signed({a[FW-1], a});
    return sat_clip(s);
  endfunction

  frc_t w_f, w_nf;

  always_comb begin : neg_force
    w_f = i_frc;
    for (int k = 0; k < 3; k++) w_nf[k] = sat_neg(w_f[k]);
  end

  // ---------------- home path ----------------
  logic            r_home_active;
  frc_t            r_home_acc;
  logic [PW-1:0]   r_home_parid;
  frc_t            r_home_frc_o;
  logic [PW-1:0]   r_home_parid_o;
  logic            r_home_valid;

  logic            w_home_emit;
  frc_t            w_home_emit_frc;
  logic [PW-1:0]   w_home_emit_parid;
  frc_t            w_home_acc_nxt;
  logic [PW-1:0]   w_home_parid_nxt;
  logic            w_home_active_nxt;
  frc_t            w_home_total;
  logic            w_home_same;

  always_comb begin : home_update
    w_home_emit       = 1'b0;
    w_home_emit_frc   = r_home_acc;
    w_home_emit_parid = r_home_parid;
    w_home_acc_nxt    = r_home_acc;
    w_home_parid_nxt  = r_home_parid;
    w_home_active_nxt = r_home_active;
    w_home_same       = r_home_active && (r_home_parid == i_home_parid);
    for (int k = 0; k < 3; k++)
      w_home_total[k] = w_home_same ? sat_add(r_home_acc[k], w_f[k]) : w_f[k];

    if (i_frc_valid) begin
      if (r_home_active && !w_home_same) begin
        // New home particle: close the old total, the new pair stays open.
        w_home_emit       = 1'b1;
        w_home_acc_nxt    = w_f;
        w_home_parid_nxt  = i_home_parid;
        w_home_active_nxt = 1'b1;
      end else if (i_home_flush) begin
        w_home_emit       = 1'b1;
        w_home_emit_frc   = w_home_total;
        w_home_emit_parid = i_home_parid;
        w_home_active_nxt = 1'b0;
      end else begin
        w_home_acc_nxt    = w_home_total;
        w_home_parid_nxt  = i_home_parid;
        w_home_active_nxt = 1'b1;
      end
    end else if (i_home_flush && r_home_active) begin
      w_home_emit       = 1'b1;
      w_home_active_nxt = 1'b0;
    end
  end

  // ---------------- neighbour slots ----------------
  logic [NS-1:0]   r_slot_active;
  frc_t            r_slot_acc   [NS];
  logic [PW-1:0]   r_slot_parid [NS];
  logic [CW-1:0]   r_slot_cid   [NS];

  logic [NS-1:0]   w_slot_active;
  frc_t            w_slot_acc   [NS];
  logic [PW-1:0]   w_slot_parid [NS];
  logic [CW-1:0]   w_slot_cid   [NS];

  logic            w_sel_onehot;
  logic            w_sel_ok;
  logic            w_bad_sel;
  logic            w_push;
  logic [EW-1:0]   w_push_data;

  assign w_sel_onehot = (i_slot_sel != '0) && ((i_slot_sel & (i_slot_sel - NS'(1))) == '0);
  assign w_sel_ok     = i_frc_valid && w_sel_onehot;
  assign w_bad_sel    = i_frc_valid && !w_sel_onehot;
  assign w_push       = w_sel_ok && i_release;

  always_comb begin : nb_update
    frc_t v_sum;
    v_sum         = '0;
    w_slot_active = r_slot_active;
    w_slot_acc    = r_slot_acc;
    w_slot_parid  = r_slot_parid;
    w_slot_cid    = r_slot_cid;
    w_push_data   = '0;
    for (int s = 0; s < NS; s++) begin
      if (w_sel_ok && i_slot_sel[s]) begin
        for (int k = 0; k < 3; k++)
          v_sum[k] = r_slot_active[s] ? sat_add(r_slot_acc[s][k], w_nf[k]) : w_nf[k];
        if (i_release) begin
          // Released result carries the metadata latched on the first hit.
          w_push_data = {v_sum,
                         r_slot_active[s] ? r_slot_parid[s] : i_nb_parid,
                         r_slot_active[s] ? r_slot_cid[s]   : i_nb_cid};
          w_slot_active[s] = 1'b0;
          w_slot_acc[s]    = '0;
        end else begin
          w_slot_acc[s]    = v_sum;
          w_slot_active[s] = 1'b1;
          if (!r_slot_active[s]) begin
            w_slot_parid[s] = i_nb_parid;
            w_slot_cid[s]   = i_nb_cid;
          end
        end
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [EW-1:0]   r_mem [FD];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_bp;
  logic [1:0]      r_err;

  logic            w_pop, w_full, w_wr_en, w_ovf;
  logic [CNTW-1:0] w_count_nxt;
  logic [EW-1:0]   w_head;

  assign w_pop       = (r_count != '0) && i_nb_ready;
  assign w_full      = (r_count == CNTW'(FD));
  assign w_wr_en     = w_push && (!w_full || w_pop);
  assign w_ovf       = w_push && w_full && !w_pop;
  assign w_count_nxt = r_count + CNTW'(w_wr_en) - CNTW'(w_pop);

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_home_active  <= 1'b0;
      r_home_acc     <= '0;
      r_home_parid   <= '0;
      r_home_frc_o   <= '0;
      r_home_parid_o <= '0;
      r_home_valid   <= 1'b0;
      r_slot_active  <= '0;
      for (int s = 0; s < NS; s++) begin
        r_slot_acc[s]   <= '0;
        r_slot_parid[s] <= '0;
        r_slot_cid[s]   <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_bp     <= 1'b0;
      r_err    <= '0;
    end else begin
      r_home_active <= w_home_active_nxt;
      r_home_acc    <= w_home_acc_nxt;
      r_home_parid  <= w_home_parid_nxt;
      r_home_valid  <= w_home_emit;
      if (w_home_emit) begin
        r_home_frc_o   <= w_home_emit_frc;
        r_home_parid_o <= w_home_emit_parid;
      end
      r_slot_active <= w_slot_active;
      r_slot_acc    <= w_slot_acc;
      r_slot_parid  <= w_slot_parid;
      r_slot_cid    <= w_slot_cid;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_bp    <= (w_count_nxt >= CNTW'(FD - 2));
      r_err   <= r_err | {w_ovf, w_bad_sel};
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign o_nb_valid      = (r_count != '0);
  assign o_nb_frc        = o_nb_valid ? w_head[EW-1 -: 3*FW] : '0;
  assign o_nb_parid      = o_nb_valid ? w_head[CW +: PW]     : '0;
  assign o_nb_cid        = o_nb_valid ? w_head[CW-1:0]       : '0;
  assign o_home_frc      = r_home_frc_o;
  assign o_home_parid    = r_home_parid_o;
  assign o_home_valid    = r_home_valid;
  assign o_back_pressure = r_bp;
  assign o_err           = r_err;
  assign o_idle          = (r_slot_active == '0) && !r_home_active && (r_count == '0);

endmodule

// File: tb/tb_pe_frc_accumulator.sv
// Directed scoreboard bench for pe_frc_accumulator (default parameters).
module tb_pe_frc_accumulator;

  localparam int FW = 32;
  localparam int PW = 9;
  localparam int CW = 3;
  localparam int NS = 4;
  localparam int FD = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_frc_valid = 1'b0;
  logic [3*FW-1:0]   i_frc = '0;
  logic [PW-1:0]     i_home_parid = '0;
  logic [PW-1:0]     i_nb_parid = '0;
  logic [3*CW-1:0]   i_nb_cid = '0;
  logic [NS-1:0]     i_slot_sel = '0;
  logic              i_release = 1'b0;
  logic              i_home_flush = 1'b0;
  logic              i_nb_ready = 1'b1;
  logic [3*FW-1:0]   o_home_frc;
  logic [PW-1:0]     o_home_parid;
  logic              o_home_valid;
  logic [3*FW-1:0]   o_nb_frc;
  logic [PW-1:0]     o_nb_parid;
  logic [3*CW-1:0]   o_nb_cid;
  logic              o_nb_valid;
  logic              o_back_pressure;
  logic              o_idle;
  logic [1:0]        o_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3*FW+PW-1:0]      home_q [$];
  logic [3*FW+PW+3*CW-1:0] nb_q   [$];

  pe_frc_accumulator #(
    .FRC_WIDTH(FW), .PARID_WIDTH(PW), .CID_WIDTH(CW), .NUM_SLOTS(NS), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .i_frc_valid(i_frc_valid), .i_frc(i_frc),
    .i_home_parid(i_home_parid), .i_nb_parid(i_nb_parid), .i_nb_cid(i_nb_cid),
    .i_slot_sel(i_slot_sel), .i_release(i_release), .i_home_flush(i_home_flush),
    .o_home_frc(o_home_frc), .o_home_parid(o_home_parid), .o_home_valid(o_home_valid),
    .o_nb_frc(o_nb_frc), .o_nb_parid(o_nb_parid), .o_nb_cid(o_nb_cid),
    .o_nb_valid(o_nb_valid), .i_nb_ready(i_nb_ready),
    .o_back_pressure(o_back_pressure), .o_idle(o_idle), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3*FW-1:0] mkf(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare any output produced this cycle against the scoreboard, then step one clock.
  task automatic cycle();
    logic [3*FW+PW-1:0]      h;
    logic [3*FW+PW+3*CW-1:0] n;
    if (o_home_valid) begin
      if (home_q.size() == 0) chk("home_unexpected", 128'(o_home_valid), 128'(0));
      else begin
        h = home_q.pop_front();
        chk("home_out", 128'({o_home_frc, o_home_parid}), 128'(h));
      end
    end
    if (o_nb_valid && i_nb_ready) begin
      if (nb_q.size() == 0) chk("nb_unexpected", 128'(o_nb_valid), 128'(0));
      else begin
        n = nb_q.pop_front();
        chk("nb_out", 128'({o_nb_frc, o_nb_parid, o_nb_cid}), 128'(n));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [PW-1:0] hp, input logic [3*FW-1:0] f,
                      input logic [PW-1:0] np, input logic [3*CW-1:0] cid,
                      input logic [NS-1:0] sel, input logic rel, input logic fl);
    i_frc_valid  = 1'b1;
    i_frc        = f;
    i_home_parid = hp;
    i_nb_parid   = np;
    i_nb_cid     = cid;
    i_slot_sel   = sel;
    i_release    = rel;
    i_home_flush = fl;
    cycle();
    i_frc_valid  = 1'b0;
    i_slot_sel   = '0;
    i_release    = 1'b0;
    i_home_flush = 1'b0;
  endtask

  task automatic flush_only();
    i_home_flush = 1'b1;
    cycle();
    i_home_flush = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) cycle();
    chk("rst_idle", 128'(o_idle), 128'(1));
    chk("rst_home_valid", 128'(o_home_valid), 128'(0));
    chk("rst_nb_valid", 128'(o_nb_valid), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    chk("rst_bp", 128'(o_back_pressure), 128'(0));
    rst = 1'b0;
    cycle();

    // 1: three pairs into slot0, release on the third, then flush home
    pair(9'd5, mkf(10, -4, 1), 9'd7, {3'd1, 3'd2, 3'd3}, 4'b0001, 1'b0, 1'b0);
    pair(9'd5, mkf(10, -4, 1), 9'd7, {3'd1, 3'd2, 3'd3}, 4'b0001, 1'b0, 1'b0);
    chk("t1_idle_busy", 128'(o_idle), 128'(0));
    nb_q.push_back({mkf(-30, 12, -3), 9'd7, 3'd1, 3'd2, 3'd3});
    pair(9'd5, mkf(10, -4, 1), 9'd7, {3'd1, 3'd2, 3'd3}, 4'b0001, 1'b1, 1'b0);
    chk("t1_nb_latency", 128'(o_nb_valid), 128'(1));
    home_q.push_back({mkf(30, -12, 3), 9'd5});
    flush_only();
    chk("t1_home_latency", 128'(o_home_valid), 128'(1));
    cycle();
    chk("t1_idle_after", 128'(o_idle), 128'(1));

    // 2: home ID change emits the old total; slot1 released on the third pair
    pair(9'd5, mkf(1, 0, 0), 9'd11, 9'd0, 4'b0010, 1'b0, 1'b0);
    pair(9'd5, mkf(2, 0, 0), 9'd11, 9'd0, 4'b0010, 1'b0, 1'b0);
    home_q.push_back({mkf(3, 0, 0), 9'd5});
    nb_q.push_back({mkf(-7, 0, 0), 9'd11, 9'd0});
    pair(9'd6, mkf(4, 0, 0), 9'd11, 9'd0, 4'b0010, 1'b1, 1'b0);
    chk("t2_home_change_pulse", 128'(o_home_valid), 128'(1));
    home_q.push_back({mkf(4, 0, 0), 9'd6});
    flush_only();
    cycle();

    // 3: interleaved slot0/slot2, release slot2; slot0 keeps its partial sum
    pair(9'd8, mkf(100, 0, 0), 9'd20, 9'o123, 4'b0001, 1'b0, 1'b0);
    pair(9'd8, mkf(100, 0, 0), 9'd22, 9'o456, 4'b0100, 1'b0, 1'b0);
    pair(9'd8, mkf(100, 0, 0), 9'd20, 9'o123, 4'b0001, 1'b0, 1'b0);
    nb_q.push_back({mkf(-200, 0, 0), 9'd22, 9'o456});
    pair(9'd8, mkf(100, 0, 0), 9'd22, 9'o456, 4'b0100, 1'b1, 1'b0);
    chk("t3_idle_busy", 128'(o_idle), 128'(0));
    // Metadata from the first hit must survive: input ID 99 is ignored.
    home_q.push_back({mkf(400, 0, 0), 9'd8});
    nb_q.push_back({mkf(-200, 0, 0), 9'd20, 9'o123});
    pair(9'd8, mkf(0, 0, 0), 9'd99, 9'o777, 4'b0001, 1'b1, 1'b1);
    cycle();
    cycle();
    chk("t3_idle_after", 128'(o_idle), 128'(1));

    // 4: saturation on both paths
    pair(9'd9, mkf(32'h7FFF_FFF0, 0, 0), 9'd40, 9'd0, 4'b1000, 1'b0, 1'b0);
    home_q.push_back({mkf(32'h7FFF_FFFF, 0, 0), 9'd9});
    nb_q.push_back({mkf(32'h8000_0001, 0, 0), 9'd40, 9'd0});
    pair(9'd9, mkf(32'h7FFF_FFF0, 0, 0), 9'd40, 9'd0, 4'b1000, 1'b1, 1'b1);
    home_q.push_back({mkf(32'h8000_0000, 0, 0), 9'd10});
    nb_q.push_back({mkf(32'h7FFF_FFFF, 0, 0), 9'd41, 9'd0});
    pair(9'd10, mkf(32'h8000_0000, 0, 0), 9'd41, 9'd0, 4'b0010, 1'b1, 1'b1);
    cycle();
    cycle();
    chk("t4_err_clear", 128'(o_err), 128'(0));

    // 5: fill FIFO with ready low, overflow on the 9th, then drain
    i_nb_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < FD) nb_q.push_back({mkf(-(i + 1), 0, 0), 9'(30 + i), 9'd0});
      pair(9'd12, mkf(i + 1, 0, 0), 9'(30 + i), 9'd0, 4'b0001, 1'b1, 1'b0);
      chk("t5_back_pressure", 128'(o_back_pressure), 128'((i + 1) >= (FD - 2)));
    end
    chk("t5_err_ovf", 128'(o_err), 128'(2'b10));
    chk("t5_valid_full", 128'(o_nb_valid), 128'(1));
    i_nb_ready = 1'b1;
    repeat (FD) cycle();
    chk("t5_drained_valid", 128'(o_nb_valid), 128'(0));
    chk("t5_drained_count", 128'(nb_q.size()), 128'(0));
    chk("t5_bp_low", 128'(o_back_pressure), 128'(0));
    home_q.push_back({mkf(45, 0, 0), 9'd12});
    flush_only();
    cycle();

    // 6: bad select drops neighbour work but home still accumulates
    pair(9'd13, mkf(5, 0, 0), 9'd50, 9'd0, 4'b0011, 1'b1, 1'b0);
    chk("t6_no_push", 128'(o_nb_valid), 128'(0));
    chk("t6_err_badsel", 128'(o_err), 128'(2'b11));
    home_q.push_back({mkf(10, 0, 0), 9'd13});
    pair(9'd13, mkf(5, 0, 0), 9'd50, 9'd0, 4'b0000, 1'b0, 1'b1);
    cycle();
    chk("t6_idle", 128'(o_idle), 128'(1));

    // Reset mid-accumulation discards partial sums
    pair(9'd14, mkf(7, 0, 0), 9'd60, 9'd0, 4'b0001, 1'b0, 1'b0);
    chk("t6_busy_pre_rst", 128'(o_idle), 128'(0));
    rst = 1'b1;
    cycle();
    chk("rst2_idle", 128'(o_idle), 128'(1));
    chk("rst2_home_frc", 128'(o_home_frc), 128'(0));
    chk("rst2_home_parid", 128'(o_home_parid), 128'(0));
    chk("rst2_home_valid", 128'(o_home_valid), 128'(0));
    chk("rst2_nb_valid", 128'(o_nb_valid), 128'(0));
    chk("rst2_nb_frc", 128'(o_nb_frc), 128'(0));
    chk("rst2_err", 128'(o_err), 128'(0));
    rst = 1'b0;
    cycle();
    home_q.push_back({mkf(1, 0, 0), 9'd14});
    nb_q.push_back({mkf(-1, 0, 0), 9'd61, 9'd0});
    pair(9'd14, mkf(1, 0, 0), 9'd61, 9'd0, 4'b0001, 1'b1, 1'b1);
    cycle();
    cycle();

    chk("home_q_empty", 128'(home_q.size()), 128'(0));
    chk("nb_q_empty", 128'(nb_q.size()), 128'(0));
    chk("final_idle", 128'(o_idle), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_frc_accumulator.md
Name: pe_frc_accumulator

Overview:
Parametrised PE back-end that takes per-pair force results from the force pipeline and produces two streams. The home stream sums home-particle force over consecutive pairs and emits one total per home particle. The neighbour stream accumulates the negated (Newton's third law) force into NUM_SLOTS one-hot-selected neighbour slots and releases each slot on command. Neighbour results go through an output FIFO with ready/valid handshake and back-pressure, for the force write-back path.

Parameters:
FRC_WIDTH, 32, signed two's-complement fixed-point width per force component
PARID_WIDTH, 9, particle ID width
CID_WIDTH, 3, cell ID width per axis
NUM_SLOTS, 4, number of neighbour accumulation slots (>=1)
FIFO_DEPTH, 8, neighbour output FIFO depth (power of 2, >=4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_frc_valid  in  1  pair force valid
i_frc  in  3*FRC_WIDTH  {fz,fy,fx} home force of the pair
i_home_parid  in  PARID_WIDTH  home particle ID
i_nb_parid  in  PARID_WIDTH  neighbour particle ID
i_nb_cid  in  3*CID_WIDTH  neighbour cell ID {z,y,x}
i_slot_sel  in  NUM_SLOTS  one-hot neighbour slot select
i_release  in  1  release selected slot after this pair (qualified by i_frc_valid)
i_home_flush  in  1  emit current home total
o_home_frc  out  3*FRC_WIDTH  home force total
o_home_parid  out  PARID_WIDTH  home particle ID of the total
o_home_valid  out  1  one-cycle pulse
o_nb_frc  out  3*FRC_WIDTH  released neighbour force
o_nb_parid  out  PARID_WIDTH  released neighbour ID
o_nb_cid  out  3*CID_WIDTH  released neighbour cell
o_nb_valid  out  1  FIFO head valid
i_nb_ready  in  1  downstream accepts head
o_back_pressure  out  1  FIFO count >= FIFO_DEPTH-2
o_idle  out  1  no active slot, no active home total, FIFO empty
o_err  out  2  sticky: [0] bad slot select, [1] FIFO overflow

Behaviour:
- Reset: all outputs 0, o_idle 1. All slots inactive, accumulators 0, home inactive, FIFO empty, o_err cleared. Reset mid-operation discards all partial sums.
- Arithmetic: per-component signed add with saturation to +/-(2^(FRC_WIDTH-1)-1). The neighbour contribution is -f. Negating the minimum value gives the maximum value.
- Home path, on i_frc_valid:
  - Home inactive: load acc=f, latch parid, set active.
  - Active and parid equal: acc+=f.
  - Active and parid differs: emit old acc/parid, then load acc=f with the new parid.
  - Emission is registered: o_home_valid is high the cycle after the triggering edge (latency 1).
- Home flush (i_home_flush):
  - With no valid, or valid with the same parid: emit the total including the input and set home inactive.
  - With a valid of a different parid: emit the old total; the new pair stays active.
  - Flush while inactive: no output.
- Neighbour path, on i_frc_valid with a one-hot i_slot_sel:
  - Inactive slot: load -f, latch parid/cid, set active.
  - Active slot: acc+=-f. Metadata is not updated.
  - Single-cycle update, so back-to-back hits on the same slot are hazard-free.
- Neighbour release: if i_release, the post-add sum and metadata are written to the FIFO at the same edge and the slot clears to inactive. o_nb_valid rises the next cycle (release-to-valid latency 1).
- Release paths run in parallel with the home path; simultaneous home emit and neighbour release are both legal.
- Bad select: zero-hot or multi-hot i_slot_sel with i_frc_valid drops the neighbour contribution, including any release, and sets o_err[0]. The home path still processes the pair.
- FIFO:
  - Show-ahead; head is popped when o_nb_valid & i_nb_ready.
  - Push and pop in the same cycle is allowed at any fill level, including full.
  - Push when full without pop: the entry is dropped, o_err[1] is set, and the slot is still cleared.
  - Upstream must stall on o_back_pressure, which is registered from the count.
- o_idle is combinational from state.

Test Plan:
1. Reset, then 3 pairs: home parid 5, f=(+10,-4,+1) each, slot0 nb 7 cid {1,2,3}, release on 3rd -> o_nb_frc=(-30,+12,-3) parid 7 cid {1,2,3}, 1 cycle after 3rd pair. Then flush -> o_home_frc=(+30,-12,+3) parid 5.
2. Home parid sequence 5,5,6 with fx=1,2,4 -> pulse (3,0,0) parid 5 the cycle after the 3rd pair. Then flush -> (4,0,0) parid 6.
3. Interleave slot0/slot2 with fx=+100 each, 4 pairs, then release slot2 -> (-200,0,0); slot0 still holds -200 and stays active; o_idle=0.
4. fx=0x7FFFFFF0 twice into home -> saturates to 0x7FFFFFFF. Input fx=0x80000000 into a slot -> neighbour 0x7FFFFFFF.
5. Hold i_nb_ready=0, release 9 entries into depth 8 -> o_back_pressure=1 at count 6, 9th dropped, o_err=2'b10. Then ready=1 drains exactly 8 in order.
6. i_slot_sel=4'b0011 with release -> no FIFO push, o_err[0]=1, home acc updated. Reset mid-accumulation -> o_idle=1 and all outputs 0 next cycle.
